// File: rtl/srl_rule_writer.sv
// Serialises one ternary rule into the SRL32 match blocks: each 5-bit key chunk
// expands to 32 match bits shifted in address-31-first, followed by a drain window.
module srl_rule_writer #(
  parameter  int SEL_W   = 3,
  parameter  int DRAIN   = 32,
  localparam int NUM_BLK = 2**SEL_W,
  localparam int KEY_W   = 5*NUM_BLK
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [KEY_W-1:0] req_key,
  input  logic [KEY_W-1:0] req_mask,
  output logic             wr,
  output logic             srl_din,
  output logic [SEL_W-1:0] blk_sel,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DRAIN} state_t;

  localparam logic [SEL_W-1:0] LAST_BLK   = SEL_W'(NUM_BLK-1);
  localparam logic [4:0]       LAST_DRAIN = 5'(DRAIN-1);

  state_t             state_reg, state_next;
  logic [4:0]         bit_cnt_reg, bit_cnt_next;
  logic [SEL_W-1:0]   blk_cnt_reg, blk_cnt_next;
  logic [4:0]         drain_cnt_reg, drain_cnt_next;
  logic [KEY_W-1:0]   key_reg, key_next;
  logic [KEY_W-1:0]   mask_reg, mask_next;

  logic               wr_reg, wr_next;
  logic               srl_din_reg, srl_din_next;
  logic [SEL_W-1:0]   blk_sel_reg, blk_sel_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic               req_ready_reg, req_ready_next;

  logic [NUM_BLK-1:0] match_blk;

  // State register: outputs are registered copies of values decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      bit_cnt_reg   <= '0;
      blk_cnt_reg   <= '0;
      drain_cnt_reg <= '0;
      key_reg       <= '0;
      mask_reg      <= '0;
      wr_reg        <= 1'b0;
      srl_din_reg   <= 1'b0;
      blk_sel_reg   <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      req_ready_reg <= 1'b1;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      blk_cnt_reg   <= blk_cnt_next;
      drain_cnt_reg <= drain_cnt_next;
      key_reg       <= key_next;
      mask_reg      <= mask_next;
      wr_reg        <= wr_next;
      srl_din_reg   <= srl_din_next;
      blk_sel_reg   <= blk_sel_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      req_ready_reg <= req_ready_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    blk_cnt_next   = blk_cnt_reg;
    drain_cnt_next = drain_cnt_reg;
    key_next       = key_reg;
    mask_next      = mask_reg;
    case (state_reg)
      ST_IDLE: begin
        bit_cnt_next   = '0;
        blk_cnt_next   = '0;
        drain_cnt_next = '0;
        if (req_valid) begin
          state_next = ST_SHIFT;
          key_next   = req_key;
          mask_next  = req_mask;
        end
      end
      ST_SHIFT: begin
        bit_cnt_next = bit_cnt_reg + 5'd1;
        if (bit_cnt_reg == 5'd31) begin
          if (blk_cnt_reg == LAST_BLK) begin
            state_next     = ST_DRAIN;
            drain_cnt_next = '0;
          end else begin
            blk_cnt_next = blk_cnt_reg + SEL_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_reg == LAST_DRAIN) begin
          state_next     = ST_IDLE;
          bit_cnt_next   = '0;
          blk_cnt_next   = '0;
          drain_cnt_next = '0;
        end else begin
          drain_cnt_next = drain_cnt_reg + 5'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Address 31-k is the bitwise inverse of the 5-bit k.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_BLK; gi++) begin : g_match
      assign match_blk[gi] =
        (((~bit_cnt_next ^ key_next[5*gi +: 5]) & ~mask_next[5*gi +: 5]) == 5'd0);
    end
  endgenerate

  always_comb begin
    wr_next        = (state_next != ST_IDLE);
    busy_next      = (state_next != ST_IDLE);
    req_ready_next = (state_next == ST_IDLE);
    blk_sel_next   = blk_cnt_next;
    srl_din_next   = (state_next == ST_SHIFT) && match_blk[blk_cnt_next];
    done_next      = (state_reg == ST_DRAIN) && (drain_cnt_reg == LAST_DRAIN);
  end

  assign wr        = wr_reg;
  assign srl_din   = srl_din_reg;
  assign blk_sel   = blk_sel_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign req_ready = req_ready_reg;

endmodule

// File: tb/tb_srl_rule_writer.sv
// Directed bench for srl_rule_writer: whole-sequence captures compared against
// hand-built expected bit patterns, plus reset and back-to-back scenarios.
module tb_srl_rule_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [39:0] req_key;
  logic [39:0] req_mask;
  logic        wr;
  logic        srl_din;
  logic [2:0]  blk_sel;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  srl_rule_writer #(.SEL_W(3), .DRAIN(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_key(req_key), .req_mask(req_mask), .wr(wr), .srl_din(srl_din),
    .blk_sel(blk_sel), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Records one sequence starting at the current cycle, ending at the first wr=0 cycle.
  task automatic capture(output logic [287:0] bits, output int len, output int sel_err,
                         output int bad_ctl, output bit first_wr, output bit end_ok,
                         output bit timeout);
    int exp_sel;
    bits = '0; len = 0; sel_err = 0; bad_ctl = 0; end_ok = 0; timeout = 1;
    first_wr = (wr === 1'b1);
    for (int c = 0; c < 400; c++) begin
      if (wr === 1'b1) begin
        if (len < 288) bits[len] = srl_din;
        exp_sel = (len < 256) ? len / 32 : 7;
        if (blk_sel !== 3'(exp_sel)) sel_err++;
        if (busy !== 1'b1 || req_ready !== 1'b0 || done !== 1'b0) bad_ctl++;
        len++;
        @(posedge clk); #1;
      end else begin
        end_ok  = (done === 1'b1 && req_ready === 1'b1 && busy === 1'b0);
        timeout = 0;
        break;
      end
    end
  endtask

  task automatic start(input logic [39:0] k, input logic [39:0] m);
    req_key = k; req_mask = m; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic check_seq(input string name, input logic [287:0] exp_bits);
    logic [287:0] bits; int len, sel_err, bad_ctl; bit first_wr, end_ok, timeout;
    capture(bits, len, sel_err, bad_ctl, first_wr, end_ok, timeout);
    $display("seq %s key=%h mask=%h wr_len=%0d ones=%0d", name, req_key, req_mask, len, $countones(bits));
    n_checks++; if (timeout) begin n_fail++; $display("FAIL %s_timeout: wr never dropped", name); end
    n_checks++; if (first_wr !== 1'b1) begin n_fail++; $display("FAIL %s_latency: wr=%b want 1", name, first_wr); end
    n_checks++; if (len !== 288) begin n_fail++; $display("FAIL %s_wr_len: got %0d want 288", name, len); end
    n_checks++; if (bits !== exp_bits) begin n_fail++; $display("FAIL %s_din: got %h want %h", name, bits, exp_bits); end
    n_checks++; if (sel_err !== 0) begin n_fail++; $display("FAIL %s_blk_sel: %0d bad cycles want 0", name, sel_err); end
    n_checks++; if (bad_ctl !== 0) begin n_fail++; $display("FAIL %s_ctl: %0d bad cycles want 0", name, bad_ctl); end
    n_checks++; if (!end_ok) begin n_fail++; $display("FAIL %s_done: done=%b ready=%b busy=%b want 1 1 0", name, done, req_ready, busy); end
  endtask

  task automatic check_done_clears(input string name);
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || wr !== 1'b0) begin
      n_fail++; $display("FAIL %s_after: done=%b wr=%b want 0 0", name, done, wr);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b0; req_key = '0; req_mask = '0;
    repeat (3) @(posedge clk); #1;
    n_checks++;
    if ({wr, srl_din, blk_sel, busy, done, req_ready} !== 8'b0000_0001) begin
      n_fail++; $display("FAIL reset_outputs: got %b want 00000001", {wr, srl_din, blk_sel, busy, done, req_ready});
    end
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (wr !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_idle: wr=%b ready=%b want 0 1", wr, req_ready);
    end
  endtask

  task automatic test_key0;
    logic [287:0] e = '0;
    for (int b = 0; b < 8; b++) e[32*b+31] = 1'b1;
    start(40'h0, 40'h0);
    check_seq("key0", e);
    check_done_clears("key0");
  endtask

  task automatic test_key_ones;
    logic [287:0] e = '0;
    for (int b = 0; b < 8; b++) e[32*b] = 1'b1;
    start(40'hFF_FFFF_FFFF, 40'h0);
    check_seq("keyones", e);
    check_done_clears("keyones");
  endtask

  task automatic test_mask_ones;
    logic [287:0] e = '0;
    for (int i = 0; i < 256; i++) e[i] = 1'b1;
    start(40'h12_3456_789A, 40'hFF_FFFF_FFFF);
    check_seq("maskones", e);
    check_done_clears("maskones");
  endtask

  task automatic test_mixed;
    logic [287:0] e = '0;
    for (int k = 8; k <= 11; k++) e[k] = 1'b1;
    for (int b = 1; b < 8; b++) e[32*b+31] = 1'b1;
    start(40'h14, 40'h3);
    check_seq("mixed", e);
    check_done_clears("mixed");
  endtask

  task automatic test_reset_mid;
    logic [287:0] e = '0;
    int dones = 0;
    for (int b = 0; b < 8; b++) e[32*b+31] = 1'b1;
    start(40'hFF_FFFF_FFFF, 40'h0);
    repeat (100) begin @(posedge clk); #1; end
    n_checks++;
    if (wr !== 1'b1) begin n_fail++; $display("FAIL midreset_pre: wr=%b want 1", wr); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++;
    if ({wr, busy, req_ready, done, blk_sel, srl_din} !== 8'b0010_0000) begin
      n_fail++; $display("FAIL midreset_state: got %b want 00100000", {wr, busy, req_ready, done, blk_sel, srl_din});
    end
    for (int c = 0; c < 300; c++) begin
      if (done === 1'b1 || wr === 1'b1) dones++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (dones !== 0) begin n_fail++; $display("FAIL midreset_nodone: %0d active cycles want 0", dones); end
    $display("midreset discarded partial rule");
    start(40'h0, 40'h0);
    check_seq("postreset", e);
    check_done_clears("postreset");
  endtask

  task automatic test_reset_priority;
    req_key = 40'h0; req_mask = 40'h0; req_valid = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 1'b0;
    n_checks++;
    if (wr !== 1'b0) begin n_fail++; $display("FAIL rstprio_edge: wr=%b want 0", wr); end
    @(posedge clk); #1;
    n_checks++;
    if (wr !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstprio_idle: wr=%b ready=%b want 0 1", wr, req_ready);
    end
    $display("rstprio request dropped under reset");
  endtask

  task automatic test_back_to_back;
    logic [287:0] ea = '0;
    logic [287:0] eb = '0;
    for (int b = 0; b < 8; b++) begin ea[32*b+31] = 1'b1; eb[32*b] = 1'b1; end
    req_key = 40'h0; req_mask = 40'h0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_key = 40'hFF_FFFF_FFFF;
    check_seq("b2b_a", ea);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_seq("b2b_b", eb);
    check_done_clears("b2b_b");
  endtask

  initial begin
    test_reset;
    test_key0;
    test_key_ones;
    test_mask_ones;
    test_mixed;
    test_reset_mid;
    test_reset_priority;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/srl_rule_writer.md
# srl_rule_writer

Sequencer that programs one ternary rule into the SRL32-based match blocks. It accepts a key/mask pair over a valid/ready handshake and expands each 5-bit key chunk into 32 match bits. It shifts those bits into the addressed block, one block after another, and drives the `wr` strobe that the SRL write counter (`sel`/`flag` generation) consumes. It is the initiating end of the SRL update interface and sits between the rule-management logic and the SRL array.

## Interface
- `SEL_W`, default 3: block-select width; number of blocks `NUM_BLK = 2**SEL_W`.
- `KEY_W`, fixed at `5*NUM_BLK` (40 by default): key and mask width.
- `DRAIN`, default 32: cycles `wr` stays high after the last data bit.
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: rule request valid.
- `req_ready` out 1: block can accept a request.
- `req_key` in KEY_W: rule key; chunk b is `req_key[5b+4:5b]`.
- `req_mask` in KEY_W: per-bit don't-care; 1 means the bit is ignored.
- `wr` out 1: write strobe to the SRL array and the write counter.
- `srl_din` out 1: serial bit shifted into the selected SRL.
- `blk_sel` out SEL_W: block currently being shifted.
- `busy` out 1: a write sequence is in progress.
- `done` out 1: one-cycle pulse when the sequence completes.

## Operation
- States:
  - IDLE: `req_ready=1`, `busy=0`.
  - SHIFT: `wr=1`, `busy=1`.
  - DRAIN: `wr=1`, `srl_din=0`, `busy=1`.
- IDLE -> SHIFT when `req_valid & req_ready` at a rising edge.
  - The same edge captures `req_key` and `req_mask` into internal registers.
  - Input changes after acceptance have no effect.
- SHIFT counters:
  - `bit_cnt` is 5 bits; `blk_cnt` is SEL_W bits; both are 0 on entry.
  - Each cycle `bit_cnt` increments.
  - When `bit_cnt==31`, `bit_cnt` wraps to 0 and `blk_cnt` increments.
- SHIFT data for cycle (blk, k):
  - Address `a = 31 - k` (5-bit).
  - Chunk c = `key_reg[5*blk+4 : 5*blk]`; chunk m = `mask_reg[5*blk+4 : 5*blk]`.
  - `srl_din = (((a ^ c) & ~m) == 0)`, so the first bit shifted lands at SRL address 31.
- SHIFT -> DRAIN after the cycle with `blk_cnt==NUM_BLK-1` and `bit_cnt==31`.
- DRAIN lasts exactly DRAIN cycles (5-bit counter, 0..DRAIN-1).
  - `blk_sel` holds `NUM_BLK-1`.
  - After the last DRAIN cycle: -> IDLE with `done=1` for one cycle.
- Total `wr`-high length per rule: `32*NUM_BLK + DRAIN` (288 by default).
  - This matches the receiver's write window of 256 shift cycles plus the 32-cycle flag window.
- Requests arriving in SHIFT or DRAIN see `req_ready=0` and are not accepted. No queueing.
- A request presented in the `done` cycle is accepted, because that cycle is IDLE.
- Mask all ones for a chunk: all 32 bits are 1 (match-any).
- Mask all zeros: exactly one 1, at `k = 31 - c`.

## Timing
- All outputs are registered.
- Reset values: `wr=0`, `srl_din=0`, `blk_sel=0`, `busy=0`, `done=0`, `req_ready=1`, state IDLE, all counters 0.
- Latency: the first `wr=1` cycle is the cycle immediately after the accepting edge. `srl_din` and `blk_sel` are valid in that same cycle (blk 0, k 0).
- `blk_sel` changes on the same edge as the first bit of the next block.
- `done` is asserted in the first cycle `wr=0` after a sequence. `req_ready` is 1 in that cycle.
- Back-to-back requests produce exactly one `wr=0` cycle between sequences, the `done` cycle. This guarantees the receiver's counters clear.
- Reset mid-operation:
  - Next cycle is IDLE with `wr=0` and all counters 0.
  - No `done` pulse is generated; the partial rule is discarded.
- Reset takes priority over a simultaneous `req_valid`; that request is not accepted.

## Test plan
- **Key 0, mask 0:** each block drives `srl_din=1` only at k=31 (256 wr cycles, 8 ones total). `wr` is high for exactly 288 cycles, then `done` pulses once.
- **Key all-ones (`0xFF_FFFF_FFFF`), mask 0:** `srl_din=1` only at k=0 of each block. `blk_sel` steps 0..7 every 32 cycles, then holds 7 through DRAIN.
- **Mask all-ones, any key:** `srl_din=1` for all 256 SHIFT cycles and 0 for all 32 DRAIN cycles.
- **Mixed rule:** chunk0 = 5'b10100 with mask 5'b00011 gives ones at a ∈ {20,21,22,23}, i.e. k ∈ {11,10,9,8}. Other chunks use key 0 and mask 0.
- **Reset asserted at wr cycle 100:** next cycle `wr=0`, `busy=0`, `req_ready=1`, and no `done`. A new request then starts cleanly at blk 0, k 0.
- **`req_valid` held high with two different rules:** the second rule is accepted in the `done` cycle and there is a single `wr=0` gap cycle. When `wr` feeds the SRL write counter, receiver `sel` tracks `blk_sel` and its flag asserts during the final 32 wr cycles of each sequence.
